// File: rtl/alu_control_pipe.sv
// LEGv8 ALU control decoder between ID and EX, registered behind valid/ready.
// Define ALU_MUL_EN to build the multi-cycle MUL path (MUL_WAIT, busy, counter).
module alu_control_pipe #(
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      instruction,
    input  logic [1:0]       ALUOp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALUcontrol,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic             r_valid;
    logic [3:0]       r_ctrl;
    logic [TAG_W-1:0] r_tag;
    logic             r_ill;
    logic [CNT_W-1:0] r_ill_cnt;

    logic             w_idle;
    logic             w_acc;
    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [TAG_W-1:0] w_mul_tag;

    always_comb begin
        w_ctrl    = 4'b1111;
        w_illegal = 1'b1;
        w_is_mul  = 1'b0;
        unique case (ALUOp)
            2'b00: begin
                w_ctrl    = 4'b0010;
                w_illegal = 1'b0;
            end
            2'b01: begin
                w_ctrl    = 4'b0111;
                w_illegal = 1'b0;
            end
            2'b10: begin
                unique case (instruction)
                    11'b10001011000: begin w_ctrl = 4'b0010; w_illegal = 1'b0; end
                    11'b11001011000: begin w_ctrl = 4'b0110; w_illegal = 1'b0; end
                    11'b10001010000: begin w_ctrl = 4'b0000; w_illegal = 1'b0; end
                    11'b10101010000: begin w_ctrl = 4'b0001; w_illegal = 1'b0; end
                    11'b11010011011: begin w_ctrl = 4'b0011; w_illegal = 1'b0; end
                    11'b11010011010: begin w_ctrl = 4'b0100; w_illegal = 1'b0; end
`ifdef ALU_MUL_EN
                    11'b10011011000: begin
                        w_ctrl    = 4'b1000;
                        w_illegal = 1'b0;
                        w_is_mul  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic IDLE     = 1'b0;
    localparam logic MUL_WAIT = 1'b1;

    logic             r_state;
    logic [3:0]       r_cnt;
    logic [TAG_W-1:0] r_mul_tag;

    assign w_idle     = (r_state == IDLE);
    assign w_mul_done = (r_state == MUL_WAIT) && (r_cnt == 4'd0);
    assign w_mul_tag  = r_mul_tag;
    assign busy       = (r_state == MUL_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_mul_tag <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_acc && w_is_mul) begin
                        r_state   <= MUL_WAIT;
                        r_cnt     <= 4'(MUL_LAT - 1);
                        r_mul_tag <= in_tag;
                    end
                end
                MUL_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= IDLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    assign w_idle     = 1'b1;
    assign w_mul_done = 1'b0;
    assign w_mul_tag  = '0;
    assign busy       = 1'b0;
`endif

    assign in_ready = w_idle && (!r_valid || out_ready);
    assign w_acc    = in_valid && in_ready;

    // A MUL accept falls through to the consume branch, emptying the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= 4'b0000;
            r_tag   <= '0;
            r_ill   <= 1'b0;
        end else if (w_acc && !w_is_mul) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_tag   <= in_tag;
            r_ill   <= w_illegal;
        end else if (w_mul_done) begin
            r_valid <= 1'b1;
            r_ctrl  <= 4'b1000;
            r_tag   <= w_mul_tag;
            r_ill   <= 1'b0;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ill_cnt <= '0;
        else if (w_acc && w_illegal && (r_ill_cnt != {CNT_W{1'b1}}))
            r_ill_cnt <= r_ill_cnt + 1'b1;
    end

    assign out_valid   = r_valid;
    assign ALUcontrol  = r_ctrl;
    assign out_tag     = r_tag;
    assign out_illegal = r_ill;
    assign illegal_cnt = r_ill_cnt;

endmodule
